// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the pushbutton front end.
package button_pkg;

    typedef enum logic [1:0] {
        MODE_TOGGLE      = 2'b00,
        MODE_LEVEL       = 2'b01,
        MODE_LONG_TOGGLE = 2'b10,
        MODE_PULSE       = 2'b11
    } mode_e;

    typedef enum logic {
        ST_RELEASED = 1'b0,
        ST_PRESSED  = 1'b1
    } btn_state_e;

    // One counter width serves both the debounce and the hold counter.
    function automatic int cnt_width(input int deb_cycles, input int long_cycles);
        return $clog2(((deb_cycles > long_cycles) ? deb_cycles : long_cycles) + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One pushbutton channel: synchroniser, debounce, press/release FSM,
// hold counter and run-time selectable output mode.
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 10
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_signal,
    input  logic [1:0] i_mode,
    input  logic       i_clear,
    output logic       o_state,
    output logic       o_press,
    output logic       o_release,
    output logic       o_long
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          deb_cnt_q, deb_cnt_d;
    logic                   deb_q, deb_d;
    btn_state_e             state_q, state_d;
    logic [CW-1:0]          hold_q, hold_d;
    logic [1:0]             mode_q;
    logic                   tog_q, tog_d;
    logic                   out_state_q, out_state_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   long_q, long_d;

    logic  synced, mismatch, flip, rise, fall, tog_ev, mode_chg;
    mode_e mode;

    assign mode = mode_e'(i_mode);

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], i_signal};
        synced    = sync_q[SYNC_STAGES-1];
        mismatch  = synced != deb_q;
        flip      = mismatch && (deb_cnt_q == DEB_LAST);
        deb_cnt_d = (!mismatch || flip) ? '0 : deb_cnt_q + CW'(1);
        deb_d     = deb_q ^ flip;
        rise      = flip && !deb_q;
        fall      = flip && deb_q;
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    hold_d  = '0;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    state_d   = ST_RELEASED;
                    release_d = 1'b1;
                    hold_d    = '0;
                end else if (hold_q != LONG_MAX) begin
                    // Saturating at LONG_MAX is what suppresses auto-repeat.
                    hold_d = hold_q + CW'(1);
                    long_d = (hold_q == LONG_MAX - CW'(1));
                end
            end
            default: state_d = ST_RELEASED;
        endcase
    end

    always_comb begin
        mode_chg = i_mode != mode_q;
        tog_ev   = ((mode == MODE_TOGGLE) && press_d) ||
                   ((mode == MODE_LONG_TOGGLE) && long_d);
        // Clear beats a coincident toggle event; the event pulse itself still goes out.
        tog_d    = (i_clear || mode_chg) ? 1'b0 : (tog_q ^ tog_ev);
        case (mode)
            MODE_LEVEL: out_state_d = deb_d;
            MODE_PULSE: out_state_d = press_d;
            default:    out_state_d = tog_d;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            sync_q      <= '0;
            deb_cnt_q   <= '0;
            deb_q       <= 1'b0;
            state_q     <= ST_RELEASED;
            hold_q      <= '0;
            mode_q      <= '0;
            tog_q       <= 1'b0;
            out_state_q <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_q       <= deb_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            mode_q      <= i_mode;
            tog_q       <= tog_d;
            out_state_q <= out_state_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign o_state   = out_state_q;
    assign o_press   = press_q;
    assign o_release = release_q;
    assign o_long    = long_q;

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel pushbutton front end: one independent button_channel per input.
module button_ctrl
    import button_pkg::*;
#(
    parameter int N_BUTTON        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int LONG_CYCLES     = 10
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_BUTTON-1:0]   i_signal,
    input  logic [2*N_BUTTON-1:0] i_mode,
    input  logic                  i_clear,
    output logic [N_BUTTON-1:0]   o_state,
    output logic [N_BUTTON-1:0]   o_press,
    output logic [N_BUTTON-1:0]   o_release,
    output logic [N_BUTTON-1:0]   o_long
);

    for (genvar g = 0; g < N_BUTTON; g++) begin : g_ch
        button_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
        ) u_ch (
            .i_clock   (i_clock),
            .i_reset   (i_reset),
            .i_signal  (i_signal[g]),
            .i_mode    (i_mode[2*g+1:2*g]),
            .i_clear   (i_clear),
            .o_state   (o_state[g]),
            .o_press   (o_press[g]),
            .o_release (o_release[g]),
            .o_long    (o_long[g])
        );
    end

endmodule

// File: tb/tb_button_ctrl.sv
// Self-checking bench for button_ctrl: directed scenarios plus random traffic
// compared each cycle against a window-based behavioural model.
module tb_button_ctrl;

    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic           i_clock = 1'b0;
    logic           i_reset;
    logic [N-1:0]   i_signal;
    logic [2*N-1:0] i_mode;
    logic           i_clear;
    logic [N-1:0]   o_state, o_press, o_release, o_long;

    int checks = 0;
    int errors = 0;

    button_ctrl #(
        .N_BUTTON(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_signal(i_signal), .i_mode(i_mode),
        .i_clear(i_clear), .o_state(o_state), .o_press(o_press),
        .o_release(o_release), .o_long(o_long)
    );

    always #5 i_clock = ~i_clock;

    // Model: raw sample chain, history of synchronised samples, and event bookkeeping.
    bit         mh[N][SYNC];
    bit         ms_hist[N][$];
    bit         mdeb[N];
    bit         mpressed[N];
    int         mpress_edge[N];
    bit         mtog[N];
    logic [1:0] mprev_mode[N];
    logic [N-1:0] e_state, e_press, e_release, e_long;
    int         edge_n;

    function automatic logic [4*N-1:0] got();
        return {o_state, o_press, o_release, o_long};
    endfunction

    function automatic logic [4*N-1:0] expv();
        return {e_state, e_press, e_release, e_long};
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            for (int k = 0; k < SYNC; k++) mh[c][k] = 1'b0;
            ms_hist[c].delete();
            mdeb[c] = 1'b0; mpressed[c] = 1'b0; mpress_edge[c] = 0;
            mtog[c] = 1'b0; mprev_mode[c] = 2'b00;
        end
        e_state = '0; e_press = '0; e_release = '0; e_long = '0;
        edge_n = 0;
    endtask

    // Debounced level flips once the last DEB synchronised samples all disagree with it.
    task automatic model_edge();
        edge_n++;
        for (int c = 0; c < N; c++) begin
            bit synced, flip, p, r, l, chg;
            logic [1:0] md;
            synced = mh[c][SYNC-1];
            for (int k = SYNC-1; k > 0; k--) mh[c][k] = mh[c][k-1];
            mh[c][0] = i_signal[c];
            ms_hist[c].push_back(synced);
            flip = 1'b0;
            if (ms_hist[c].size() >= DEB) begin
                flip = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (ms_hist[c][ms_hist[c].size()-1-j] == mdeb[c]) flip = 1'b0;
            end
            p = flip && !mdeb[c];
            r = flip && mdeb[c];
            if (flip) mdeb[c] = ~mdeb[c];
            l = 1'b0;
            if (p) begin
                mpressed[c] = 1'b1; mpress_edge[c] = edge_n;
            end else if (r) begin
                mpressed[c] = 1'b0;
            end else if (mpressed[c] && (edge_n - mpress_edge[c] == LONG)) begin
                l = 1'b1;
            end
            md  = i_mode[2*c +: 2];
            chg = md != mprev_mode[c];
            mprev_mode[c] = md;
            if (i_clear || chg) mtog[c] = 1'b0;
            else if ((md == 2'b00 && p) || (md == 2'b10 && l)) mtog[c] = ~mtog[c];
            e_press[c]   = p;
            e_release[c] = r;
            e_long[c]    = l;
            e_state[c]   = (md == 2'b01) ? mdeb[c] : (md == 2'b11) ? p : mtog[c];
        end
    endtask

    task automatic step();
        @(posedge i_clock);
        if (!i_reset) model_edge();
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (got() !== '0) begin errors++; $display("FAIL reset_async: got %h expected 0", got()); end
        repeat (3) begin
            @(posedge i_clock); #1;
            i_signal = N'($urandom);
            checks++;
            if (got() !== '0) begin errors++; $display("FAIL reset_held: got %h expected 0", got()); end
        end
        i_signal = '0;
        i_reset  = 1'b0;
        model_reset();
        repeat (4) begin
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL reset_idle: got %h expected %h", got(), expv()); end
        end
    endtask

    task automatic test_clean_press();
        for (int ph = 0; ph < 3; ph++) begin
            i_signal[0] = (ph != 1);
            for (int e = 0; e < 20; e++) begin
                step();
                checks++;
                if (got() !== expv()) begin errors++; $display("FAIL clean_model ph%0d e%0d: got %h expected %h", ph, e, got(), expv()); end
                if (e == 4) begin
                    checks++;
                    if (o_press[0] !== 1'b0 || o_release[0] !== 1'b0) begin
                        errors++; $display("FAIL clean_early ph%0d: press %b release %b expected 0 0", ph, o_press[0], o_release[0]);
                    end
                end
                if (e == 5) begin
                    checks++;
                    if ({o_press[0], o_release[0], o_state[0]} !== ((ph == 0) ? 3'b101 : (ph == 1) ? 3'b011 : 3'b100)) begin
                        errors++; $display("FAIL clean_edge5 ph%0d: press/release/state %b%b%b", ph, o_press[0], o_release[0], o_state[0]);
                    end
                end
            end
        end
        i_signal[0] = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_bounce();
        int np = 0, at = -1;
        for (int c = 0; c < 30; c++) begin
            i_signal[1] = (c % 6) < 3;
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL bounce_model c%0d: got %h expected %h", c, got(), expv()); end
            if (o_press[1]) np++;
        end
        checks++;
        if (np != 0) begin errors++; $display("FAIL bounce_reject: got %0d presses expected 0", np); end
        i_signal[1] = 1'b1;
        for (int e = 0; e < 20; e++) begin
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL bounce_hold_model e%0d: got %h expected %h", e, got(), expv()); end
            if (o_press[1]) begin np++; at = e; end
        end
        checks++;
        if (np != 1 || at != 5) begin errors++; $display("FAIL bounce_accept: got %0d presses at %0d expected 1 at 5", np, at); end
        i_signal[1] = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_long_press();
        int nl = 0;
        i_mode[5:4] = 2'b10;
        i_signal[2] = 1'b1;
        for (int e = 0; e < 25; e++) begin
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL long_model e%0d: got %h expected %h", e, got(), expv()); end
            if (o_long[2]) nl++;
            if (e == 14 || e == 15) begin
                checks++;
                if ({o_long[2], o_state[2]} !== ((e == 15) ? 2'b11 : 2'b00)) begin
                    errors++; $display("FAIL long_edge e%0d: long/state %b%b", e, o_long[2], o_state[2]);
                end
            end
        end
        checks++;
        if (nl != 1) begin errors++; $display("FAIL long_once: got %0d long pulses expected 1", nl); end
        i_signal[2] = 1'b0;
        repeat (15) step();
        nl = 0;
        for (int e = 0; e < 30; e++) begin
            i_signal[2] = e < 8;
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL short_model e%0d: got %h expected %h", e, got(), expv()); end
            if (o_long[2]) nl++;
        end
        checks++;
        if (nl != 0 || o_state[2] !== 1'b1) begin
            errors++; $display("FAIL short_press: got %0d long pulses state %b expected 0 and 1", nl, o_state[2]);
        end
    endtask

    task automatic test_clear_collision();
        i_signal[0] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            i_clear = (e == 5);
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL clear_model e%0d: got %h expected %h", e, got(), expv()); end
            if (e == 5) begin
                checks++;
                if ({o_press[0], o_state[0]} !== 2'b10) begin
                    errors++; $display("FAIL clear_collision: press/state %b%b expected 10", o_press[0], o_state[0]);
                end
            end
        end
        i_clear = 1'b0;
        for (int ph = 0; ph < 2; ph++) begin
            i_signal[0] = (ph == 1);
            repeat (10) step();
        end
        checks++;
        if (o_state[0] !== 1'b1) begin errors++; $display("FAIL toggle_set: state %b expected 1", o_state[0]); end
        i_mode[1:0] = 2'b01;
        step();
        i_mode[1:0] = 2'b00;
        step();
        checks++;
        if (o_state[0] !== 1'b0 || got() !== expv()) begin
            errors++; $display("FAIL mode_change_clear: state %b got %h expected 0 / %h", o_state[0], got(), expv());
        end
        i_signal[0] = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset_mid_hold();
        i_mode[7:6] = 2'b01;
        i_signal[3] = 1'b1;
        repeat (10) step();
        checks++;
        if (o_state[3] !== 1'b1) begin errors++; $display("FAIL level_hold: state %b expected 1", o_state[3]); end
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (got() !== '0) begin errors++; $display("FAIL midhold_async: got %h expected 0", got()); end
        repeat (3) begin
            @(posedge i_clock); #1;
            i_signal = N'($urandom) | N'(8);
            checks++;
            if (got() !== '0) begin errors++; $display("FAIL midhold_held: got %h expected 0", got()); end
        end
        i_signal = 4'b1000;
        i_reset  = 1'b0;
        for (int e = 0; e < 10; e++) begin
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL midhold_model e%0d: got %h expected %h", e, got(), expv()); end
            if (e == 4 || e == 5) begin
                checks++;
                if ({o_press[3], o_state[3]} !== ((e == 5) ? 2'b11 : 2'b00)) begin
                    errors++; $display("FAIL midhold_repress e%0d: press/state %b%b", e, o_press[3], o_state[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        i_mode = 8'($urandom);
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) i_signal[b] = ~i_signal[b];
            if ($urandom_range(49) == 0) i_mode = 8'($urandom);
            i_clear = ($urandom_range(29) == 0);
            step();
            checks++;
            if (got() !== expv()) begin errors++; $display("FAIL random c%0d: got %h expected %h", c, got(), expv()); end
        end
        i_clear = 1'b0;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_signal = N'($urandom);
        i_mode   = '0;
        i_clear  = 1'b0;
        model_reset();
        test_reset();
        test_clean_press();
        test_bounce();
        test_long_press();
        test_clear_collision();
        test_reset_mid_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_ctrl.md
# button_ctrl

Parametrised multi-channel pushbutton front end: synchronises raw button inputs, debounces them, detects press/release/long-press events, and produces a per-channel output state whose meaning is selected at run time (toggle, level, long-press toggle, pulse). Sits between board pins and the control logic as the successor to the single-purpose toggle logic. Unlike that logic, it also handles metastability, contact bounce and hold detection.

## Interface
- N_BUTTON, 4, number of independent channels
- SYNC_STAGES, 2, synchroniser flops per channel (≥2)
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a level change (≥1)
- LONG_CYCLES, 10, cycles a debounced press must be held to raise a long-press event (≥1)

- i_clock  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_signal  in  N_BUTTON  raw button inputs, asynchronous, active-high
- i_mode  in  2*N_BUTTON  per-channel mode, channel i uses bits [2i+1:2i]
- i_clear  in  1  synchronous clear of all toggle states
- o_state  out  N_BUTTON  per-channel state, meaning set by mode
- o_press  out  N_BUTTON  one-cycle pulse on debounced rising edge
- o_release  out  N_BUTTON  one-cycle pulse on debounced falling edge
- o_long  out  N_BUTTON  one-cycle pulse when press held LONG_CYCLES

## Operation
- Reset: synchroniser flops, debounced level, counters, toggle registers and all outputs go to 0.
- Synchroniser: SYNC_STAGES-flop chain per channel. All downstream logic uses only the last stage.
- Debounce counter per channel:
  - Increments each cycle that the synced input differs from the debounced level.
  - Clears to 0 on any cycle they are equal.
  - When the counter equals DEBOUNCE_CYCLES−1 and a mismatch is still present, the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- Per-channel FSM:
  - RELEASED → PRESSED on a debounced rise: o_press pulse, hold counter cleared.
  - PRESSED → RELEASED on a debounced fall: o_release pulse.
- Hold counter:
  - In PRESSED, increments every cycle.
  - When it reaches LONG_CYCLES, o_long pulses once and the counter saturates. There is no auto-repeat.
  - Cleared on release.
- Modes (shared package enum):
  - 00 TOGGLE: toggle register flips on each o_press.
  - 01 LEVEL: o_state = debounced level.
  - 10 LONG_TOGGLE: toggle register flips on each o_long only.
  - 11 PULSE: o_state = o_press.
  - In TOGGLE and LONG_TOGGLE, o_state = toggle register.
- Mode change: a cycle where i_mode[i] differs from its previous-cycle value clears channel i's toggle register. Debounce and FSM state are unaffected.
- i_clear clears all toggle registers. If it coincides with a toggle event, clear wins (state 0), but the event pulse is still emitted.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- All outputs are registered. No combinational path exists from any input to any output.
- Edge 0 is the first clock edge sampling a new stable raw level.
- The debounced level, o_press/o_release and toggle-mode o_state change at edge SYNC_STAGES+DEBOUNCE_CYCLES−1 (edge 5 at defaults).
- o_long fires at press edge + LONG_CYCLES.
- Reset mid-operation:
  - Outputs clear immediately (asynchronously).
  - If a button is held across reset release, the chain re-detects it as a new press, with o_press at edge SYNC_STAGES+DEBOUNCE_CYCLES−1 after release.

## Structure
- Package button_pkg holds:
  - mode enum: MODE_TOGGLE, MODE_LEVEL, MODE_LONG_TOGGLE, MODE_PULSE.
  - counter-width function: $clog2 of max(DEBOUNCE_CYCLES, LONG_CYCLES)+1.
- Sub-module button_channel holds the single-channel synchroniser, debounce, FSM, hold counter and mode mux.
- Top level instantiates N_BUTTON channels with a generate loop and fans out i_clear.

## Test plan
Defaults apply: N=4, SYNC=2, DEB=4, LONG=10.
- Reset: assert i_reset with random i_signal → all outputs 0 within the same cycle and held 0 until release.
- Clean press, ch0 TOGGLE: raise i_signal[0] at edge 0 and hold 20 cycles → o_press[0] and o_state[0]=1 at edge 5. Release, then repeat the press → o_release, then o_state[0]=0 on the second press.
- Bounce, ch1 TOGGLE: alternate 3 cycles high / 3 cycles low for 30 cycles → no o_press. Then hold high → exactly one o_press, 5 edges after the final rise.
- Long press, ch2 LONG_TOGGLE: hold 20 cycles → o_long[2] and o_state[2]=1 at edge 15. A separate 8-cycle press → no o_long and no state change.
- Clear collision, ch0 TOGGLE: i_clear=1 on the press edge → o_press[0]=1 and o_state[0]=0. Also: mode change 00→01 with toggle=1 → toggle register cleared.
- Reset mid-hold, ch3 LEVEL: i_reset asserted while debounced=1 → o_state[3]=0 immediately. Release reset with input still high → o_press[3] and o_state[3]=1 at edge 5 after release.
